prog_counter_stack: RTL and testbench

Program counter for the RAT MCU with an integrated hardware return-address stack; it drives the 10-bit fetch address into the program ROM.
- The ROM registers its output, so the instruction at PC_COUNT appears on the ROM output one cycle after PC_COUNT changes.
- The control unit issues one PC operation per cycle. INT_REQ overrides that operation and vectors to the interrupt handler.

---
 rtl/prog_counter_stack.sv | 133 +++++++++++++
 tb/tb_prog_counter_stack.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter_stack.sv
// prog_counter_stack
//   Program counter for the RAT MCU with an integrated LIFO return-address stack.
//   PC_COUNT feeds the program ROM address input directly from a register.
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-high reset
//   PC_OP       in   000 NOP, 001 INC, 010 JUMP, 011 CALL, 100 RET, 101 LOAD_RESET, else NOP
//   FROM_IMMED  in   branch/call target
//   INT_REQ     in   interrupt request; overrides PC_OP for the cycle
//   ERR_CLR     in   clears STK_ERR (a new error in the same cycle wins)
//   PC_COUNT    out  current fetch address (registered)
//   STK_DEPTH   out  number of stack entries in use
//   STK_EMPTY   out  STK_DEPTH == 0
//   STK_FULL    out  STK_DEPTH == STACK_DEPTH
//   STK_ERR     out  sticky overflow/underflow flag
module prog_counter_stack #(
    parameter int unsigned       ADDR_W      = 10,
    parameter int unsigned       STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_W-1:0] INT_VECTOR  = '1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [2:0]                     PC_OP,
    input  logic [ADDR_W-1:0]              FROM_IMMED,
    input  logic                           INT_REQ,
    input  logic                           ERR_CLR,
    output logic [ADDR_W-1:0]              PC_COUNT,
    output logic [$clog2(STACK_DEPTH):0]   STK_DEPTH,
    output logic                           STK_EMPTY,
    output logic                           STK_FULL,
    output logic                           STK_ERR
);

    localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);
    localparam int unsigned DEPTH_W = PTR_W + 1;

    localparam logic [2:0] OpInc       = 3'b001;
    localparam logic [2:0] OpJump      = 3'b010;
    localparam logic [2:0] OpCall      = 3'b011;
    localparam logic [2:0] OpRet       = 3'b100;
    localparam logic [2:0] OpLoadReset = 3'b101;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               err_set;
    logic               push_en;
    logic [ADDR_W-1:0]  push_data;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  top_entry;
    logic [ADDR_W-1:0]  pc_plus1;
    logic               full, empty;

    assign full      = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty     = (depth_q == '0);
    assign pc_plus1  = pc_q + ADDR_W'(1);
    // Combinational read of the top entry so RET completes in a single cycle.
    assign top_entry = stack_q[PTR_W'(depth_q - DEPTH_W'(1))];

    always_comb begin
        pc_d      = pc_q;
        depth_d   = depth_q;
        err_set   = 1'b0;
        push_en   = 1'b0;
        push_data = pc_q;
        if (INT_REQ) begin
            // Save the preempted fetch address so RET resumes it.
            if (full) begin
                err_set = 1'b1;
            end else begin
                push_en   = 1'b1;
                push_data = pc_q;
                pc_d      = INT_VECTOR;
                depth_d   = depth_q + DEPTH_W'(1);
            end
        end else begin
            unique case (PC_OP)
                OpInc:  pc_d = pc_plus1;
                OpJump: pc_d = FROM_IMMED;
                OpCall: begin
                    if (full) begin
                        err_set = 1'b1;
                    end else begin
                        push_en   = 1'b1;
                        push_data = pc_plus1;
                        pc_d      = FROM_IMMED;
                        depth_d   = depth_q + DEPTH_W'(1);
                    end
                end
                OpRet: begin
                    if (empty) begin
                        err_set = 1'b1;
                    end else begin
                        pc_d    = top_entry;
                        depth_d = depth_q - DEPTH_W'(1);
                    end
                end
                OpLoadReset: pc_d = RESET_ADDR;
                default: ;  // NOP and illegal codes hold all state
            endcase
        end
        // Set has priority over clear.
        err_d = err_set | (err_q & ~ERR_CLR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= RESET_ADDR;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[depth_q[PTR_W-1:0]] <= push_data;
        end
    end

    assign PC_COUNT  = pc_q;
    assign STK_DEPTH = depth_q;
    assign STK_EMPTY = empty;
    assign STK_FULL  = full;
    assign STK_ERR   = err_q;

endmodule

// File: tb/tb_prog_counter_stack.sv
// tb_prog_counter_stack
//   Self-checking bench for prog_counter_stack. A queue-based reference model tracks
//   the PC, the return-address stack and the sticky error flag.
module tb_prog_counter_stack;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] PC_OP = 3'b000;
    logic [9:0] FROM_IMMED = '0;
    logic       INT_REQ = 1'b0;
    logic       ERR_CLR = 1'b0;
    logic [9:0] PC_COUNT;
    logic [3:0] STK_DEPTH;
    logic       STK_EMPTY, STK_FULL, STK_ERR;

    prog_counter_stack dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC_OP      (PC_OP),
        .FROM_IMMED (FROM_IMMED),
        .INT_REQ    (INT_REQ),
        .ERR_CLR    (ERR_CLR),
        .PC_COUNT   (PC_COUNT),
        .STK_DEPTH  (STK_DEPTH),
        .STK_EMPTY  (STK_EMPTY),
        .STK_FULL   (STK_FULL),
        .STK_ERR    (STK_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model
    int m_pc = 0;
    int m_stack[$];
    bit m_err = 1'b0;

    logic [16:0] obs;
    assign obs = {PC_COUNT, STK_DEPTH, STK_EMPTY, STK_FULL, STK_ERR};

    function automatic logic [16:0] exp_vec();
        logic [9:0] p;
        logic [3:0] d;
        p = 10'(m_pc);
        d = 4'(m_stack.size());
        return {p, d, m_stack.size() == 0, m_stack.size() == 8, m_err};
    endfunction

    function automatic void model_step(input int op, input int imm, input bit intr,
                                       input bit clr);
        bit e = 1'b0;
        if (intr) begin
            if (m_stack.size() == 8) e = 1'b1;
            else begin m_stack.push_back(m_pc); m_pc = 'h3FF; end
        end else begin
            case (op)
                1: m_pc = (m_pc + 1) % 1024;
                2: m_pc = imm;
                3: if (m_stack.size() == 8) e = 1'b1;
                   else begin m_stack.push_back((m_pc + 1) % 1024); m_pc = imm; end
                4: if (m_stack.size() == 0) e = 1'b1;
                   else m_pc = m_stack.pop_back();
                5: m_pc = 0;
                default: ;
            endcase
        end
        m_err = e | (m_err & !clr);
    endfunction

    function automatic void model_reset();
        m_pc = 0;
        m_stack.delete();
        m_err = 1'b0;
    endfunction

    // Drive one operation, clock it, update the model, sample 1 time unit after the edge.
    task automatic cycle(input logic [2:0] op, input logic [9:0] imm, input bit intr,
                         input bit clr);
        PC_OP = op; FROM_IMMED = imm; INT_REQ = intr; ERR_CLR = clr;
        @(posedge CLK);
        model_step(int'(op), int'(imm), intr, clr);
        #1;
        PC_OP = 3'b000; INT_REQ = 1'b0; ERR_CLR = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #3;
        model_reset();
        checks++;
        if (obs !== exp_vec()) begin
            $display("FAIL reset_state: got %h expected %h", obs, exp_vec());
            errors++;
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(3'b001, '0, 0, 0);
        checks++;
        if (PC_COUNT !== 10'h005) begin
            $display("FAIL inc_x5: got %h expected 005", PC_COUNT); errors++;
        end
        cycle(3'b011, 10'h100, 0, 0);
        checks++;
        if (obs !== exp_vec()) begin
            $display("FAIL call_100: got %h expected %h", obs, exp_vec()); errors++;
        end
        #2 RST = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({PC_COUNT, STK_DEPTH, STK_ERR, STK_EMPTY} !== {10'h000, 4'd0, 1'b0, 1'b1}) begin
            $display("FAIL async_reset: got %h/%0d/%b expected 000/0/0",
                     PC_COUNT, STK_DEPTH, STK_ERR);
            errors++;
        end
        #2 RST = 1'b0;
        cycle(3'b001, '0, 0, 0);
        checks++;
        if (obs !== exp_vec() || PC_COUNT !== 10'h001) begin
            $display("FAIL inc_after_reset: got %h expected %h", obs, exp_vec()); errors++;
        end
    endtask

    task automatic test_wrap();
        logic [9:0] seq [3];
        seq[0] = 10'h3FE; seq[1] = 10'h3FF; seq[2] = 10'h000;
        cycle(3'b010, 10'h3FE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cycle(3'b001, '0, 0, 0);
            checks++;
            if (PC_COUNT !== seq[i] || STK_ERR !== 1'b0 || obs !== exp_vec()) begin
                $display("FAIL wrap_%0d: got pc %h err %b expected pc %h err 0",
                         i, PC_COUNT, STK_ERR, seq[i]);
                errors++;
            end
        end
    endtask

    task automatic test_nested();
        logic [2:0]  ops  [4];
        logic [9:0]  imms [4];
        logic [9:0]  pcs  [4];
        logic [3:0]  deps [4];
        ops[0] = 3'b011; imms[0] = 10'h200; pcs[0] = 10'h200; deps[0] = 4'd1;
        ops[1] = 3'b011; imms[1] = 10'h300; pcs[1] = 10'h300; deps[1] = 4'd2;
        ops[2] = 3'b100; imms[2] = 10'h000; pcs[2] = 10'h201; deps[2] = 4'd1;
        ops[3] = 3'b100; imms[3] = 10'h000; pcs[3] = 10'h011; deps[3] = 4'd0;
        cycle(3'b010, 10'h010, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(ops[i], imms[i], 0, 0);
            checks++;
            if (PC_COUNT !== pcs[i] || STK_DEPTH !== deps[i] || obs !== exp_vec()) begin
                $display("FAIL nested_%0d: got pc %h depth %0d expected pc %h depth %0d",
                         i, PC_COUNT, STK_DEPTH, pcs[i], deps[i]);
                errors++;
            end
        end
        checks++;
        if (STK_EMPTY !== 1'b1) begin
            $display("FAIL nested_empty: got %b expected 1", STK_EMPTY); errors++;
        end
    endtask

    task automatic test_overflow();
        cycle(3'b010, 10'h020, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cycle(3'b011, 10'h050, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin
                $display("FAIL overflow_call_%0d: got %h expected %h", i, obs, exp_vec());
                errors++;
            end
        end
        checks++;
        if ({PC_COUNT, STK_DEPTH, STK_ERR, STK_FULL} !== {10'h050, 4'd8, 1'b1, 1'b1}) begin
            $display("FAIL overflow_9th: got pc %h depth %0d err %b full %b expected 050/8/1/1",
                     PC_COUNT, STK_DEPTH, STK_ERR, STK_FULL);
            errors++;
        end
        for (int i = 0; i < 8; i++) begin
            cycle(3'b100, '0, 0, 0);
            checks++;
            if (PC_COUNT !== ((i == 7) ? 10'h021 : 10'h051) || obs !== exp_vec()) begin
                $display("FAIL overflow_ret_%0d: got %h expected %h", i, obs, exp_vec());
                errors++;
            end
        end
        cycle(3'b000, '0, 0, 1);
        checks++;
        if (STK_ERR !== 1'b0) begin
            $display("FAIL overflow_clear: got %b expected 0", STK_ERR); errors++;
        end
    endtask

    task automatic test_underflow();
        cycle(3'b010, 10'h040, 0, 0);
        cycle(3'b100, '0, 0, 0);
        checks++;
        if (PC_COUNT !== 10'h040 || STK_ERR !== 1'b1) begin
            $display("FAIL underflow: got pc %h err %b expected 040/1", PC_COUNT, STK_ERR);
            errors++;
        end
        cycle(3'b000, '0, 0, 1);
        checks++;
        if (STK_ERR !== 1'b0) begin
            $display("FAIL err_clr: got %b expected 0", STK_ERR); errors++;
        end
        cycle(3'b100, '0, 0, 1);
        checks++;
        if (STK_ERR !== 1'b1 || PC_COUNT !== 10'h040) begin
            $display("FAIL set_wins: got err %b pc %h expected 1/040", STK_ERR, PC_COUNT);
            errors++;
        end
        cycle(3'b000, '0, 0, 1);
    endtask

    task automatic test_interrupt();
        cycle(3'b010, 10'h0A5, 0, 0);
        cycle(3'b011, 10'h123, 1, 0);
        checks++;
        if (PC_COUNT !== 10'h3FF || STK_DEPTH !== 4'd1 || obs !== exp_vec()) begin
            $display("FAIL int_vector: got pc %h depth %0d expected 3FF/1", PC_COUNT, STK_DEPTH);
            errors++;
        end
        cycle(3'b100, '0, 0, 0);
        checks++;
        if (PC_COUNT !== 10'h0A5 || STK_DEPTH !== 4'd0) begin
            $display("FAIL int_return: got pc %h depth %0d expected 0A5/0", PC_COUNT, STK_DEPTH);
            errors++;
        end
        // Interrupt against a full stack
        for (int i = 0; i < 8; i++) cycle(3'b011, 10'(i * 16), 0, 0);
        cycle(3'b001, '0, 1, 0);
        checks++;
        if (obs !== exp_vec() || STK_ERR !== 1'b1) begin
            $display("FAIL int_full: got %h expected %h", obs, exp_vec()); errors++;
        end
    endtask

    task automatic test_illegal();
        for (int op = 6; op < 8; op++) begin
            cycle(3'(op), 10'h155, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin
                $display("FAIL illegal_op_%0d: got %h expected %h", op, obs, exp_vec());
                errors++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(3'($urandom_range(0, 7)), 10'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            checks++;
            if (obs !== exp_vec()) begin
                $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        // Alternate CALL/RET with no idle cycles between them
        for (int i = 0; i < 20; i++) begin
            cycle((i % 2 == 0) ? 3'b011 : 3'b100, 10'($urandom), 0, 0);
            checks++;
            if (obs !== exp_vec()) begin
                $display("FAIL back_to_back_%0d: got %h expected %h", i, obs, exp_vec());
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_wrap();
        test_nested();
        test_overflow();
        test_underflow();
        test_interrupt();
        test_illegal();
        test_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
